fetch_ctrl: RTL and testbench

Instruction-fetch controller that sequences the combinational instruction ROM (`instr_mem`). Holds the program counter, drives the ROM word address, registers the returned instruction into a valid/ready output stage for decode, and handles back-pressure, control-flow redirects, halt requests and `ebreak` self-halt. Sits between `instr_mem` and the decode stage inside the control unit; `instr_mem` is instantiated beside it, not inside it.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_ctrl.sv | 86 ++++++++
 tb/tb_fetch_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;
  localparam logic [31:0] PC_STEP      = 32'd4;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: sequences a combinational ROM, registers each
// word into a valid/ready output stage, and handles redirect, halt and ebreak.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          ADDRESS_WIDTH = 8,
  parameter int          DATA_WIDTH    = 32,
  parameter logic [31:0] RESET_PC      = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  input  logic                     halt_req,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic [31:0]              out_pc,
  output logic                     halted,
  output logic [31:0]              instr_count
);

  localparam logic [DATA_WIDTH-1:0] EBREAK_WORD = DATA_WIDTH'(EBREAK_INSTR);

  // Handshake: a word transfers to decode on every cycle where out_valid and
  // out_ready are both high; while out_valid is high and out_ready is low the
  // output stage and pc hold unchanged. A redirect flushes regardless.

  fetch_state_t state, state_next;
  logic [31:0]  pc;
  logic         load;
  logic         accept;

  assign accept   = out_valid && out_ready;
  assign load     = (state == RUN) && !redirect_valid && !halt_req && (!out_valid || out_ready);
  assign mem_addr = pc[ADDRESS_WIDTH+1:2];
  assign halted   = (state == HALTED);

  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      state_next = RUN;
    end else if (state == RUN && (halt_req || (load && mem_rdata == EBREAK_WORD))) begin
      state_next = HALTED;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
    end else if (redirect_valid) begin
      pc        <= {redirect_pc[31:2], 2'b00};
      out_valid <= 1'b0;
    end else if (load) begin
      out_instr <= mem_rdata;
      out_pc    <= pc;
      out_valid <= 1'b1;
      pc        <= pc + PC_STEP;
    end else if (accept) begin
      out_valid <= 1'b0;
    end
  end

  // A word flushed by a same-cycle redirect is not counted as delivered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_count <= '0;
    end else if (accept && !redirect_valid) begin
      instr_count <= instr_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vectors, a spec-level model checked every
// cycle, plus literal expectations at key points; a second 2-bit-address DUT covers wrap.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam logic [31:0] A0 = 32'hA0A0_0000, A1 = 32'hA1A1_0004;
  localparam logic [31:0] A2 = 32'hA2A2_0008, A3 = 32'hA3A3_000C;

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] opc;
    logic        halted;
    logic [31:0] count;
  } model_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid, halt_req, out_ready;
  logic [31:0] redirect_pc;

  logic [7:0]  mem_addr8;
  logic [31:0] mem_rdata8, out_instr8, out_pc8, instr_count8;
  logic        out_valid8, halted8;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_rdata2, out_instr2, out_pc2, instr_count2;
  logic        out_valid2, halted2;

  logic [31:0] rom8[256];
  logic [31:0] rom2[4];
  model_t      m8, m2;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] c0;

  always #5 clk = ~clk;

  assign mem_rdata8 = rom8[mem_addr8];
  assign mem_rdata2 = rom2[mem_addr2];

  fetch_ctrl #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32), .RESET_PC(32'h0)) dut8 (
    .clk(clk), .rst(rst), .mem_addr(mem_addr8), .mem_rdata(mem_rdata8),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .out_valid(out_valid8), .out_ready(out_ready), .out_instr(out_instr8),
    .out_pc(out_pc8), .halted(halted8), .instr_count(instr_count8)
  );

  fetch_ctrl #(.ADDRESS_WIDTH(2), .DATA_WIDTH(32), .RESET_PC(32'h0)) dut2 (
    .clk(clk), .rst(rst), .mem_addr(mem_addr2), .mem_rdata(mem_rdata2),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2),
    .out_pc(out_pc2), .halted(halted2), .instr_count(instr_count2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level behaviour of one clock edge given the current ROM word at pc.
  function automatic model_t step(model_t s, logic [31:0] word, logic rv, logic [31:0] rpc,
                                  logic hr, logic rdy);
    model_t n;
    n = s;
    if (rv) begin
      n.pc     = rpc & ~32'd3;
      n.valid  = 1'b0;
      n.halted = 1'b0;
    end else begin
      if (s.valid && rdy) n.count = s.count + 32'd1;
      if (!s.halted && !hr && (!s.valid || rdy)) begin
        n.instr = word;
        n.opc   = s.pc;
        n.valid = 1'b1;
        n.pc    = s.pc + 32'd4;
        if (word == 32'h0010_0073) n.halted = 1'b1;
      end else begin
        if (s.valid && rdy) n.valid = 1'b0;
        if (!s.halted && hr) n.halted = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m8 <= '0;
      m2 <= '0;
    end else begin
      m8 <= step(m8, rom8[(m8.pc / 4) % 256], redirect_valid, redirect_pc, halt_req, out_ready);
      m2 <= step(m2, rom2[(m2.pc / 4) % 4], redirect_valid, redirect_pc, halt_req, out_ready);
    end
  end

  always @(negedge clk) begin
    check("valid8", {31'd0, out_valid8}, {31'd0, m8.valid});
    check("halted8", {31'd0, halted8}, {31'd0, m8.halted});
    check("count8", instr_count8, m8.count);
    check("addr8", {24'd0, mem_addr8}, (m8.pc / 4) % 256);
    check("instr8", out_instr8, m8.instr);
    check("opc8", out_pc8, m8.opc);
    check("valid2", {31'd0, out_valid2}, {31'd0, m2.valid});
    check("addr2", {30'd0, mem_addr2}, (m2.pc / 4) % 4);
    check("opc2", out_pc2, m2.opc);
    check("count2", instr_count2, m2.count);
  end

  initial begin
    for (int i = 0; i < 256; i++) rom8[i] = 32'h1000_0000 + i;
    rom8[0] = A0; rom8[1] = A1; rom8[2] = A2; rom8[3] = A3;
    rom2[0] = 32'hB0; rom2[1] = 32'hB1; rom2[2] = 32'hB2; rom2[3] = 32'hB3;
    rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0;

    // Reset state and first fetches
    repeat (2) @(negedge clk);
    check("rst_valid", {31'd0, out_valid8}, 32'd0);
    check("rst_addr", {24'd0, mem_addr8}, 32'd0);
    check("rst_count", instr_count8, 32'd0);
    check("rst_halted", {31'd0, halted8}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("first_valid", {31'd0, out_valid8}, 32'd1);
    check("first_pc", out_pc8, 32'h0);
    check("first_instr", out_instr8, A0);
    @(negedge clk); check("seq_pc4", out_pc8, 32'h4); check("seq_i1", out_instr8, A1);
    @(negedge clk); check("seq_pc8", out_pc8, 32'h8);
    @(negedge clk); check("seq_pcC", out_pc8, 32'hC); check("wrap_addr2", {30'd0, mem_addr2}, 32'd0);
    @(negedge clk);
    check("count4", instr_count8, 32'd4);
    check("wrap_pc2", out_pc2, 32'h10);
    check("wrap_instr2", out_instr2, 32'hB0);

    // Back-pressure at out_pc = 4
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    @(negedge clk); redirect_valid = 1'b0; check("redir0_flush", {31'd0, out_valid8}, 32'd0);
    @(negedge clk); check("bp_pc0", out_pc8, 32'h0);
    @(negedge clk); check("bp_pc4", out_pc8, 32'h4); out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_pc", out_pc8, 32'h4);
      check("bp_hold_instr", out_instr8, A1);
      check("bp_hold_addr", {24'd0, mem_addr8}, 32'd2);
    end
    out_ready = 1'b1;
    @(negedge clk); check("bp_next_pc", out_pc8, 32'h8); check("bp_next_instr", out_instr8, A2);

    // Redirect to 0x22 while stalled
    out_ready = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h22; c0 = instr_count8;
    @(negedge clk);
    check("flush_valid", {31'd0, out_valid8}, 32'd0);
    check("flush_count", instr_count8, c0);
    redirect_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("redir_pc", out_pc8, 32'h20);
    check("redir_count", instr_count8, c0);
    // Flush with out_ready high: the flushed word is not counted
    redirect_valid = 1'b1; redirect_pc = 32'h0; c0 = instr_count8;
    @(negedge clk);
    check("flush_rdy_count", instr_count8, c0);
    redirect_valid = 1'b0;

    // ebreak at word 2
    rom8[2] = EBREAK_INSTR;
    @(negedge clk); check("eb_pc0", out_pc8, 32'h0);
    @(negedge clk); check("eb_pc4", out_pc8, 32'h4);
    @(negedge clk);
    check("eb_pc8", out_pc8, 32'h8);
    check("eb_instr", out_instr8, EBREAK_INSTR);
    check("eb_halted", {31'd0, halted8}, 32'd1);
    @(negedge clk); check("eb_stop", {31'd0, out_valid8}, 32'd0);
    halt_req = 1'b1;
    @(negedge clk); check("eb_still", {31'd1, halted8}, 32'hFFFF_FFFF >> 31 | 32'd0 | {31'd1, 1'b1});
    halt_req = 1'b0;
    check("eb_addr", {24'd0, mem_addr8}, 32'd3);
    rom8[2] = A2; redirect_valid = 1'b1; redirect_pc = 32'h0;
    @(negedge clk); redirect_valid = 1'b0; check("eb_resume_halted", {31'd0, halted8}, 32'd0);
    @(negedge clk); check("eb_resume_pc", out_pc8, 32'h0);

    // halt_req together with redirect, then halt_req alone
    redirect_valid = 1'b1; halt_req = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    check("hr_rd_halted", {31'd0, halted8}, 32'd0);
    redirect_valid = 1'b0; halt_req = 1'b0;
    @(negedge clk); check("hr_pc40", out_pc8, 32'h40);
    @(negedge clk); check("hr_pc44", out_pc8, 32'h44);
    halt_req = 1'b1;
    @(negedge clk); check("hr_halted", {31'd0, halted8}, 32'd1);
    halt_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hr_frozen_addr", {24'd0, mem_addr8}, 32'd18);
      check("hr_no_valid", {31'd0, out_valid8}, 32'd0);
    end

    // Reset mid-operation clears immediately
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    @(negedge clk); redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, out_valid8}, 32'd0);
    check("arst_count", instr_count8, 32'd0);
    check("arst_addr", {24'd0, mem_addr8}, 32'd0);
    check("arst_pc", out_pc8, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); check("arst_first_pc", out_pc8, 32'h0); check("arst_first_instr", out_instr8, A0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
